// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared constants and state encoding for the tile scheduler and its row FIFO.
package matmul_tile_scheduler_pkg;

  localparam int S2P_SIZE       = 4;
  localparam int RESULT_SIZE    = 8;
  localparam int ROW_W          = S2P_SIZE * RESULT_SIZE;
  localparam int CNT_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 2 * S2P_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5
  } sched_state_e;

  // FIFO entries carry the end-of-job marker in the MSB above the row payload.
  function automatic logic [ROW_W:0] pack_row(input logic last, input logic [ROW_W-1:0] data);
    return {last, data};
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// Tile-buffer handshake, matrix_mul control/result and row-stream signals.
interface matmul_tile_scheduler_if #(
  parameter int CNT_W = 8
);
  import matmul_tile_scheduler_pkg::*;

  logic             tile_req;
  logic             tile_valid;
  logic [CNT_W-1:0] tile_idx;
  logic             flag_buffer;
  logic [1:0]       mm_done;
  logic [ROW_W-1:0] mm_product;
  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] row_data;
  logic             row_last;

  modport master (
    output tile_req, tile_idx, flag_buffer, row_valid, row_data, row_last,
    input  tile_valid, mm_done, mm_product, row_ready
  );

  modport slave (
    input  tile_req, tile_idx, flag_buffer, row_valid, row_data, row_last,
    output tile_valid, mm_done, mm_product, row_ready
  );

endinterface

// File: rtl/matmul_tile_scheduler_fifo.sv
// Result row FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module result_row_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Stale storage is masked so an empty FIFO presents an all-zero head.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Job sequencer for the S2P tile multiplier: fetches tile pairs, pulses the
// matrix_mul load and buffers result rows for the downstream consumer.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | tile_req high, waiting for tile_valid and room for a full tile of rows
// LOAD    | one-cycle flag_buffer pulse, buffer data still held by tile_req
// COMPUTE | capturing result rows on mm_done[0] until mm_done[1]
// FLUSH   | all tiles computed, draining the row FIFO
// DONE    | one-cycle job_done pulse
module matmul_tile_scheduler
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [CNT_W-1:0]        i_num_tiles,
  output logic                    o_busy,
  output logic                    o_job_done,
  output logic                    o_err_ovf,
  matmul_tile_scheduler_if.master bus
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int RCW = $clog2(S2P_SIZE + 1);
  localparam logic [FCW-1:0] SPACE_LIMIT = FCW'(FIFO_DEPTH - S2P_SIZE);

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_num_tiles;
  logic [CNT_W-1:0] r_tile_idx;
  logic [RCW-1:0]   r_row_cnt;
  logic             r_err_ovf;

  logic             w_start_ok;
  logic             w_in_compute;
  logic             w_row_done;
  logic             w_tile_done;
  logic             w_last_tile;
  logic             w_space_ok;
  logic             w_push;
  logic             w_push_last;
  logic             w_pop;
  logic             w_ovf;
  logic             w_tile_req;
  logic             w_flag_buffer;
  logic             w_busy;
  logic             w_job_done;

  logic [ROW_W:0]   w_fifo_head;
  logic [FCW-1:0]   w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign w_row_done   = bus.mm_done[0];
  assign w_tile_done  = bus.mm_done[1];
  assign w_in_compute = (r_state == ST_COMPUTE);
  assign w_start_ok   = (r_state == ST_IDLE) && i_start;
  assign w_last_tile  = (r_tile_idx == (r_num_tiles - CNT_W'(1)));
  assign w_space_ok   = (w_fifo_count <= SPACE_LIMIT);

  assign w_pop       = !w_fifo_empty && bus.row_ready;
  assign w_push      = w_in_compute && w_row_done && (!w_fifo_full || w_pop);
  assign w_push_last = w_last_tile && w_tile_done;
  // Any row strobe that cannot be stored is lost and flagged.
  assign w_ovf       = w_row_done && (!w_in_compute || (w_fifo_full && !w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tile_req    = 1'b0;
    w_flag_buffer = 1'b0;
    w_busy        = 1'b1;
    w_job_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_start) w_state_nxt = (i_num_tiles == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        w_tile_req = 1'b1;
        if (bus.tile_valid && w_space_ok) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_tile_req    = 1'b1;
        w_flag_buffer = 1'b1;
        w_state_nxt   = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (w_tile_done) w_state_nxt = w_last_tile ? ST_FLUSH : ST_FETCH;
      end
      ST_FLUSH: begin
        if (w_fifo_empty) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_job_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_tiles <= '0;
      r_tile_idx  <= '0;
      r_row_cnt   <= '0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_num_tiles <= i_num_tiles;
        r_tile_idx  <= '0;
        r_row_cnt   <= '0;
      end else if (w_in_compute && w_tile_done) begin
        r_tile_idx <= r_tile_idx + CNT_W'(1);
        r_row_cnt  <= '0;
      end else if (w_push) begin
        r_row_cnt <= r_row_cnt + RCW'(1);
      end
      // A fresh job clears the flag, but an error in the same cycle still wins.
      r_err_ovf <= (r_err_ovf && !w_start_ok) || w_ovf;
    end
  end

  result_row_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_row_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (pack_row(w_push_last, bus.mm_product)),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign o_busy          = w_busy;
  assign o_job_done      = w_job_done;
  assign o_err_ovf       = r_err_ovf;
  assign bus.tile_req    = w_tile_req;
  assign bus.tile_idx    = r_tile_idx;
  assign bus.flag_buffer = w_flag_buffer;
  assign bus.row_valid   = !w_fifo_empty;
  assign bus.row_data    = w_fifo_head[ROW_W-1:0];
  assign bus.row_last    = w_fifo_head[ROW_W];

endmodule
